multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle sequencer for the MIPS-subset CPU: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared-ALU, single-memory datapath: PC, IR, register file, ALU-input muxes and memory enables. It also counts retired instructions and flags unsupported opcodes. It sits beside the datapath, reading only the IR opcode field and the ALU zero flag.

## Interface
- COUNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag; valid in BRANCH
- pc_write  out  1  load PC (unconditional, or branch taken)
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  load IR from memory data
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B input: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct decode, 11 = lui (imm<<16)
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse in the final state of every legal instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- instr_count  out  COUNT_W  retired instructions; wraps modulo 2^COUNT_W
- state_dbg  out  4  current state encoding

## Operation
- Opcodes: R = 000000, beq = 000100, bne = 000101, j = 000010, lw = 100011, sw = 101011, addi = 001000, lui = 001111.
- States and encodings: RST = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6, EXECUTE = 7, R_WB = 8, BRANCH = 9, JUMP = 10, IMM_EXEC = 11, IMM_WB = 12. Encodings 13–15 go to FETCH.
- RST: all outputs 0 except state_dbg = 0. Next state is FETCH.
- FETCH: mem_read, ir_write, pc_write; i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
- DECODE: latch opcode into op_q; alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Dispatch on opcode:
  - lw/sw → MEM_ADDR
  - R → EXECUTE
  - beq/bne → BRANCH
  - j → JUMP
  - addi/lui → IMM_EXEC
  - anything else → FETCH with illegal_op = 1
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next is MEM_READ if op_q = lw, else MEM_WRITE.
- MEM_READ: mem_read, i_or_d = 1 → MEM_WB.
- MEM_WB: reg_write, mem_to_reg = 1, reg_dst = 0, retire → FETCH.
- MEM_WRITE: mem_write, i_or_d = 1, retire → FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10 → R_WB.
- R_WB: reg_write, reg_dst = 1, mem_to_reg = 0, retire → FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01; retire → FETCH.
  - pc_write = zero for beq, and ~zero for bne.
- JUMP: pc_write, pc_source = 10, retire → FETCH.
- IMM_EXEC: alu_src_a = 1, alu_src_b = 10; alu_op = 00 for addi, 11 for lui → IMM_WB.
- IMM_WB: reg_write, reg_dst = 0, mem_to_reg = 0, retire → FETCH.
- Any signal not listed for a state is 0.
- instr_count increments on every clk edge where retire = 1. illegal_op does not count.

## Timing
- Outputs are combinational from state (and op_q). pc_write in BRANCH additionally depends on zero.
- Cycles per instruction:
  - lw: 5
  - R, sw, addi, lui: 4
  - beq, bne, j: 3
  - illegal: 2
- Reset: rst = 1 forces state = RST, op_q = 0 and instr_count = 0 immediately. The first rising edge with rst = 0 enters FETCH.
- Reset asserted mid-instruction aborts it: no retire, no counter update, and no further strobes after assertion.
- Counter wrap: at all-ones, a retire gives 0.
- An opcode change after DECODE has no effect on sequencing, because op_q is used.

## Structure
- Package mc_pkg holds:
  - opcode localparams
  - state encodings
  - ALUOp, alu_src_b and pc_source encodings
- One sub-module: mc_next_state, the purely combinational next-state and dispatch logic.
- The top level holds:
  - the state register
  - op_q
  - the counter
  - the output decode

## Test plan
- Reset: rst pulse → all outputs 0, state_dbg = 0. First edge after release → state_dbg = 1 with mem_read = ir_write = pc_write = 1.
- lw (100011) → state sequence 1, 2, 3, 4, 5, 1. MEM_WB has reg_write = 1 and mem_to_reg = 1. instr_count goes 0 → 1.
- beq (000100):
  - with zero = 1 → pc_write = 1 and pc_source = 01 in state 9
  - repeat with bne (000101) and zero = 1 → pc_write = 0
- opcode 111111 → states 1, 2, 1; illegal_op pulses once; instr_count unchanged.
- R, addi, lui, sw, j back to back → total cycles 4 + 4 + 4 + 4 + 3 = 19; instr_count = 5; the lui IMM_EXEC has alu_op = 11.
- COUNT_W = 2 with 5 retires → instr_count = 1. rst asserted during MEM_READ → state 0 immediately, count cleared.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes, FSM states and
// the datapath mux/ALU select codes.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_IMM_EXEC  = 4'd11,
        S_IMM_WB    = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LUI   = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state and opcode dispatch for the multicycle sequencer.
// DECODE dispatches on the live opcode; later states use the latched op_q.
module mc_next_state
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] op_q,
    output state_t     next_state,
    output logic       illegal
);

    // Next-state selection; anything unrecognised falls back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_RST:      next_state = S_FETCH;
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    next_state = S_MEM_ADDR;
                    OP_R:            next_state = S_EXECUTE;
                    OP_BEQ, OP_BNE:  next_state = S_BRANCH;
                    OP_J:            next_state = S_JUMP;
                    OP_ADDI, OP_LUI: next_state = S_IMM_EXEC;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: next_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: next_state = S_MEM_WB;
            S_EXECUTE:  next_state = S_R_WB;
            S_IMM_EXEC: next_state = S_IMM_WB;
            default:    next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS-subset datapath. Holds the state
// register, the latched opcode and the retired-instruction counter, and
// decodes datapath controls from the current state.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic               pc_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               retire,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state_dbg
);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic       illegal;

    mc_next_state u_next (
        .state      (state),
        .opcode     (opcode),
        .op_q       (op_q),
        .next_state (next_state),
        .illegal    (illegal)
    );

    // State register; reset drops straight to RST so strobes stop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RST;
        else     state <= next_state;
    end

    // Capture the opcode in DECODE so later IR changes cannot redirect us.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    op_q <= 6'd0;
        else if (state == S_DECODE) op_q <= opcode;
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instr_count <= '0;
        else if (retire) instr_count <= instr_count + 1'b1;
    end

    assign state_dbg = state;

    // Per-state datapath control decode; every control defaults low.
    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_source  = PCSRC_ALU;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = illegal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (op_q == OP_BNE) ? ~zero : zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (op_q == OP_LUI) ? ALU_LUI : ALU_ADD;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a 16-bit counter instance plus a
// 2-bit counter instance sharing the same stimulus.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;

    logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, retire, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [15:0] instr_count;
    logic [3:0]  state_dbg;

    logic        pc_write2, i_or_d2, mem_read2, mem_write2, ir_write2, reg_dst2;
    logic        mem_to_reg2, reg_write2, alu_src_a2, retire2, illegal_op2;
    logic [1:0]  alu_src_b2, alu_op2, pc_source2;
    logic [1:0]  instr_count2;
    logic [3:0]  state_dbg2;

    // Control bundle order: pc_write,i_or_d,mem_read,mem_write,ir_write,
    // reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_source,
    // retire,illegal_op
    logic [16:0] ctl;
    assign ctl = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, retire, illegal_op};

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .retire(retire), .illegal_op(illegal_op), .instr_count(instr_count),
        .state_dbg(state_dbg)
    );

    multicycle_control #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_write(pc_write2), .i_or_d(i_or_d2), .mem_read(mem_read2),
        .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
        .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .pc_source(pc_source2),
        .retire(retire2), .illegal_op(illegal_op2), .instr_count(instr_count2),
        .state_dbg(state_dbg2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, release it away from an edge, then step into FETCH.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 17'd0 || state_dbg !== 4'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ctl=%b state=%0d want ctl=0 state=0", ctl, state_dbg);
        end
        n_cmp++;
        if (instr_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", instr_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (state_dbg !== 4'd0) begin
            n_err++;
            $display("FAIL reset_hold: state=%0d want 0", state_dbg);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 4'd1 || ctl !== 17'b1_0_1_0_1_0_0_0_0_01_00_00_0_0) begin
            n_err++;
            $display("FAIL fetch_entry: state=%0d ctl=%b want 1 ctl=%b",
                     state_dbg, ctl, 17'b1_0_1_0_1_0_0_0_0_01_00_00_0_0);
        end
    endtask

    task automatic test_lw();
        logic [3:0] want [5];
        want = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (state_dbg !== want[i]) begin
                n_err++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_dbg, want[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (ctl !== 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0) begin
                    n_err++;
                    $display("FAIL decode_ctl: got %b want %b", ctl, 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (ctl !== 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0 || instr_count !== 16'd0) begin
                    n_err++;
                    $display("FAIL mem_wb: ctl=%b cnt=%0d want %b cnt=0",
                             ctl, instr_count, 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0);
                end
            end
        end
        n_cmp++;
        if (instr_count !== 16'd1) begin
            n_err++;
            $display("FAIL lw_count: got %0d want 1", instr_count);
        end
    endtask

    task automatic test_branch();
        // beq, zero = 1: taken
        opcode = 6'b000100;
        zero = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state_dbg !== 4'd9 || ctl !== 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0) begin
            n_err++;
            $display("FAIL beq_taken: state=%0d ctl=%b want 9 ctl=%b",
                     state_dbg, ctl, 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0);
        end
        tick();
        // bne, zero = 1: not taken; then zero = 0: taken
        opcode = 6'b000101;
        tick();
        tick();
        n_cmp++;
        if (state_dbg !== 4'd9 || pc_write !== 1'b0 || pc_source !== 2'b01) begin
            n_err++;
            $display("FAIL bne_zero1: state=%0d pc_write=%b pc_source=%b want 9 0 01",
                     state_dbg, pc_write, pc_source);
        end
        zero = 1'b0;
        #1;
        n_cmp++;
        if (pc_write !== 1'b1) begin
            n_err++;
            $display("FAIL bne_zero0: pc_write=%b want 1", pc_write);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 4'd1 || instr_count !== 16'd3) begin
            n_err++;
            $display("FAIL branch_done: state=%0d cnt=%0d want 1 3", state_dbg, instr_count);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        tick();
        n_cmp++;
        if (state_dbg !== 4'd2 || illegal_op !== 1'b1 || retire !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_decode: state=%0d illegal=%b retire=%b want 2 1 0",
                     state_dbg, illegal_op, retire);
        end
        tick();
        n_cmp++;
        if (state_dbg !== 4'd1 || illegal_op !== 1'b0 || instr_count !== 16'd3) begin
            n_err++;
            $display("FAIL illegal_after: state=%0d illegal=%b cnt=%0d want 1 0 3",
                     state_dbg, illegal_op, instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [5];
        int  cycles;
        bit  done;
        bit  saw_lui;
        bit  saw_sw_write;
        ops = '{6'b000000, 6'b001000, 6'b001111, 6'b101011, 6'b000010};
        cycles = 0;
        saw_lui = 1'b0;
        saw_sw_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            tick();
            cycles++;
            done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                // Disturb the opcode once op_q holds sw; must stay a store.
                if (i == 3 && state_dbg == 4'd3) opcode = 6'b100011;
                tick();
                cycles++;
                if (i == 2 && state_dbg == 4'd11) begin
                    saw_lui = 1'b1;
                    n_cmp++;
                    if (alu_op !== 2'b11 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin
                        n_err++;
                        $display("FAIL lui_exec: alu_op=%b srcb=%b srca=%b want 11 10 1",
                                 alu_op, alu_src_b, alu_src_a);
                    end
                end
                if (i == 3 && state_dbg == 4'd6) saw_sw_write = 1'b1;
                if (state_dbg == 4'd1) done = 1'b1;
            end
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL b2b_timeout: instr %0d state=%0d want return to 1", i, state_dbg);
            end
        end
        n_cmp++;
        if (cycles != 19 || instr_count !== 16'd8) begin
            n_err++;
            $display("FAIL b2b_totals: cycles=%0d cnt=%0d want 19 8", cycles, instr_count);
        end
        n_cmp++;
        if (!saw_lui || !saw_sw_write) begin
            n_err++;
            $display("FAIL b2b_paths: lui_exec_seen=%0d sw_write_seen=%0d want 1 1",
                     saw_lui, saw_sw_write);
        end
        n_cmp++;
        if (instr_count2 !== 2'd0) begin
            n_err++;
            $display("FAIL narrow_wrap8: got %0d want 0", instr_count2);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        opcode = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            tick();
        end
        n_cmp++;
        if (instr_count !== 16'd5 || instr_count2 !== 2'd1) begin
            n_err++;
            $display("FAIL counter_wrap: cnt16=%0d cnt2=%0d want 5 1", instr_count, instr_count2);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        tick();
        tick();
        tick();
        n_cmp++;
        if (state_dbg !== 4'd4 || mem_read !== 1'b1 || i_or_d !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: state=%0d mem_read=%b i_or_d=%b want 4 1 1",
                     state_dbg, mem_read, i_or_d);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (state_dbg !== 4'd0 || ctl !== 17'd0 || instr_count !== 16'd0 || instr_count2 !== 2'd0) begin
            n_err++;
            $display("FAIL mid_reset: state=%0d ctl=%b cnt=%0d cnt2=%0d want 0 0 0 0",
                     state_dbg, ctl, instr_count, instr_count2);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (state_dbg !== 4'd1 || instr_count !== 16'd0) begin
            n_err++;
            $display("FAIL mid_recover: state=%0d cnt=%0d want 1 0", state_dbg, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_counter_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
